iq_interleaver: RTL and testbench
=================================

Name: iq_interleaver

Overview:
- Producer end of the interleaved complex-sample stream consumed by the magnitude-squared stage.
- Accepts one parallel I/Q pair per cycle from the DDC/ADC side, which has no backpressure, and buffers pairs in a small FIFO.
- Emits each pair as two beats on a single DW-wide stream: real first, then imag with last asserted, under a valid/ready handshake.
- Sits between the front-end sample source and the magnitude/detection chain.

Parameters:
- DW, 16, sample width in bits for each of I and Q.
- DEPTH, 8, FIFO depth in I/Q pairs; must be a power of 2, minimum 2.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- i_i  input  DW  in-phase sample.
- q_i  input  DW  quadrature sample.
- valid_i  input  1  i_i/q_i carry a new pair this cycle.
- clr_ovf_i  input  1  synchronous clear of overflow_o.
- data_o  output  DW  interleaved output beat.
- valid_o  output  1  data_o/last_o valid.
- last_o  output  1  high on the imag beat.
- ready_i  input  1  downstream accepts the beat.
- level_o  output  $clog2(DEPTH)+1  pairs held, including the pair currently being emitted.
- overflow_o  output  1  sticky: a pair was dropped.

Behaviour:
- Interface decision: one clock (clk); reset rst is asynchronous and active-low.
- Reset (rst low), asynchronous:
  - FIFO pointers and level cleared; state = REAL.
  - data_o=0, valid_o=0, last_o=0, level_o=0, overflow_o=0.
  - Reset asserted mid-pair discards the pair: no imag beat follows after reset release.
- Storage: FIFO of {I,Q} pairs, 2*DW bits per entry. Write pointer and read pointer wrap modulo DEPTH.
- Write rule:
  - Pair is written when valid_i=1 and the FIFO is not full.
  - Pair is also written when the FIFO is full and the head pair pops in the same cycle.
  - Otherwise the pair is dropped and overflow_o is set the next cycle.
- overflow_o:
  - Cleared by clr_ovf_i=1.
  - If clr_ovf_i and a drop occur in the same cycle, set wins.
- Output state machine, state register is REAL or IMAG:
  - REAL: valid_o = (level>0); data_o = head I; last_o=0. Handshake (valid_o & ready_i) -> IMAG.
  - IMAG: valid_o=1; data_o = head Q; last_o=1. Handshake -> pop head, go to REAL.
  - Without handshake, the state holds.
- Stability: once valid_o=1, data_o/last_o hold unchanged until handshake. Incoming writes never alter the head entry.
- All outputs are driven from registers or the storage array; there is no combinational path from i_i/q_i/valid_i to any output. ready_i -> valid_o path is not permitted.
- Latency: a pair written into an empty FIFO at edge N gives real beat valid_o=1 in the cycle after edge N. With ready_i held high, the imag beat follows one cycle later.
- Throughput:
  - One pair per 2 cycles sustained.
  - Input arriving faster than that fills the FIFO.
  - After DEPTH (+1 per pop in the window) excess pairs, drops occur.
- level_o:
  - +1 on write, -1 on pop, unchanged when both happen in the same cycle.
  - Range 0..DEPTH.
- Empty: valid_o=0 in REAL; data_o holds last value (don't-care).

Optional Feature:
- Macro: IQ_INTERLEAVER_DROP_CNT_EN.
- Defined:
  - Adds output drop_cnt_o [15:0].
  - Increments on each dropped pair and saturates at 16'hFFFF.
  - Cleared by clr_ovf_i together with overflow_o; an increment in the clearing cycle wins and gives value 1.
  - Reset value 0.
- Undefined: port and counter absent; overflow_o behaviour unchanged.

Test Plan:
- Single pair: I=16'h1234, Q=16'hABCD, ready_i=1 -> beat 1: data_o=1234/last_o=0; beat 2: data_o=ABCD/last_o=1; level_o 1->0; then valid_o=0.
- Backpressure: 3 pairs in, ready_i low for 10 cycles -> valid_o=1 with data_o=I0 stable throughout, level_o=3. Release -> I0,Q0,I1,Q1,I2,Q2 in order, last_o on every second beat.
- Overflow, DEPTH=8, ready_i=0: 10 consecutive valid_i pairs -> level_o=8, overflow_o=1, pairs 9-10 never appear. clr_ovf_i pulse -> overflow_o=0. With macro: drop_cnt_o=2, then 0 after clear.
- Full with simultaneous pop: FIFO full, ready_i=1 in IMAG, valid_i=1 -> pair accepted, level_o stays 8, overflow_o stays 0.
- Wrap-around: stream 40 pairs with ready_i toggling 50% -> output sequence matches input order exactly, no drops while level_o<8.
- Reset mid-pair: assert rst low after real beat accepted -> all outputs 0 immediately. After release, valid_o=0 until new valid_i; no orphan imag beat.

Source files
------------

// File: rtl/iq_interleaver.sv
// iq_interleaver: buffers parallel I/Q pairs in a FIFO and emits them as real/imag beats on one stream.
// Optional drop counter output drop_cnt_o enabled by IQ_INTERLEAVER_DROP_CNT_EN.
module iq_interleaver #(
    parameter int DW    = 16,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [DW-1:0]              i_i,
    input  logic [DW-1:0]              q_i,
    input  logic                       valid_i,
    input  logic                       clr_ovf_i,
    output logic [DW-1:0]              data_o,
    output logic                       valid_o,
    output logic                       last_o,
    input  logic                       ready_i,
    output logic [$clog2(DEPTH):0]     level_o,
`ifdef IQ_INTERLEAVER_DROP_CNT_EN
    output logic [15:0]                drop_cnt_o,
`endif
    output logic                       overflow_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    typedef enum logic {REAL, IMAG} state_e;

    logic [2*DW-1:0] mem_q [DEPTH];
    logic [2*DW-1:0] mem_d [DEPTH];
    logic [AW-1:0]   wr_q, wr_d, rd_q, rd_d;
    logic [LW-1:0]   level_q, level_d;
    state_e          state_q, state_d;
    logic            ovf_q, ovf_d;
    logic            hs, pop, wr, drop;

    assign valid_o    = (state_q == IMAG) || (level_q != '0);
    assign last_o     = (state_q == IMAG);
    assign data_o     = (state_q == IMAG) ? mem_q[rd_q][DW-1:0] : mem_q[rd_q][2*DW-1:DW];
    assign level_o    = level_q;
    assign overflow_o = ovf_q;

    // A full FIFO still accepts when the head pair leaves in the same cycle.
    always_comb begin
        hs      = valid_o && ready_i;
        pop     = hs && (state_q == IMAG);
        wr      = valid_i && ((level_q != LW'(DEPTH)) || pop);
        drop    = valid_i && !wr;
        mem_d   = mem_q;
        if (wr) mem_d[wr_q] = {i_i, q_i};
        wr_d    = wr_q + AW'(wr);
        rd_d    = rd_q + AW'(pop);
        level_d = level_q + LW'(wr) - LW'(pop);
        state_d = hs ? ((state_q == REAL) ? IMAG : REAL) : state_q;
        ovf_d   = drop || (ovf_q && !clr_ovf_i);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_q   <= '{default: '0};
            wr_q    <= '0;
            rd_q    <= '0;
            level_q <= '0;
            state_q <= REAL;
            ovf_q   <= 1'b0;
        end else begin
            mem_q   <= mem_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            level_q <= level_d;
            state_q <= state_d;
            ovf_q   <= ovf_d;
        end
    end

`ifdef IQ_INTERLEAVER_DROP_CNT_EN
    logic [15:0] cnt_q, cnt_d;

    assign drop_cnt_o = cnt_q;

    always_comb begin
        cnt_d = drop ? (clr_ovf_i ? 16'd1 : cnt_q + 16'(cnt_q != 16'hFFFF))
                     : (clr_ovf_i ? 16'd0 : cnt_q);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) cnt_q <= '0;
        else      cnt_q <= cnt_d;
    end
`endif
endmodule

// File: tb/tb_iq_interleaver.sv
// tb_iq_interleaver: directed and randomized checks of iq_interleaver against a queue-based pair model.
module tb_iq_interleaver;
    localparam int DW    = 16;
    localparam int DEPTH = 8;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic          clk, rst;
    logic [DW-1:0] i_i, q_i, data_o;
    logic          valid_i, clr_ovf_i, valid_o, last_o, ready_i, overflow_o;
    logic [LW-1:0] level_o;
`ifdef IQ_INTERLEAVER_DROP_CNT_EN
    logic [15:0]   drop_cnt_o;
`endif

    iq_interleaver #(.DW(DW), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .i_i(i_i), .q_i(q_i), .valid_i(valid_i),
        .clr_ovf_i(clr_ovf_i), .data_o(data_o), .valid_o(valid_o), .last_o(last_o),
        .ready_i(ready_i), .level_o(level_o),
`ifdef IQ_INTERLEAVER_DROP_CNT_EN
        .drop_cnt_o(drop_cnt_o),
`endif
        .overflow_o(overflow_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors = 0;
    int errors  = 0;

    // Model: pending pairs in arrival order, plus whether the real half of the head has gone out.
    logic [2*DW-1:0] mq[$];
    logic            half  = 1'b0;
    logic            m_ovf = 1'b0;
    logic [15:0]     m_cnt = '0;

    logic [DW-1:0] ov_i[10], ov_q[10];

    task automatic model_reset();
        mq.delete();
        half  = 1'b0;
        m_ovf = 1'b0;
        m_cnt = '0;
    endtask

    // Drive one cycle of inputs from a negedge, advance the model, return at the next negedge.
    task automatic tick(input logic vi, input logic [DW-1:0] ii, input logic [DW-1:0] qq,
                        input logic rdy, input logic clr);
        logic hs, pop, acc, drop;
        valid_i = vi; i_i = ii; q_i = qq; ready_i = rdy; clr_ovf_i = clr;
        hs  = (mq.size() > 0) && rdy;
        pop = hs && half;
        if (hs) half = !half;
        acc = vi && ((mq.size() < DEPTH) || pop);
        if (pop) void'(mq.pop_front());
        if (acc) mq.push_back({ii, qq});
        drop  = vi && !acc;
        m_ovf = drop || (m_ovf && !clr);
        m_cnt = drop ? (clr ? 16'd1 : (m_cnt == 16'hFFFF ? m_cnt : m_cnt + 16'd1))
                     : (clr ? 16'd0 : m_cnt);
        @(negedge clk);
    endtask

    task automatic test_reset();
        vectors++; if (valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", valid_o); end
        vectors++; if (last_o !== 1'b0) begin errors++; $display("FAIL reset_last got=%b exp=0", last_o); end
        vectors++; if (data_o !== '0) begin errors++; $display("FAIL reset_data got=%h exp=0", data_o); end
        vectors++; if (level_o !== '0) begin errors++; $display("FAIL reset_level got=%0d exp=0", level_o); end
        vectors++; if (overflow_o !== 1'b0) begin errors++; $display("FAIL reset_ovf got=%b exp=0", overflow_o); end
`ifdef IQ_INTERLEAVER_DROP_CNT_EN
        vectors++; if (drop_cnt_o !== '0) begin errors++; $display("FAIL reset_cnt got=%0d exp=0", drop_cnt_o); end
`endif
    endtask

    task automatic test_single();
        tick(1'b1, 16'h1234, 16'hABCD, 1'b1, 1'b0);
        vectors++; if (valid_o !== 1'b1 || data_o !== 16'h1234 || last_o !== 1'b0)
            begin errors++; $display("FAIL single_real got v=%b d=%h l=%b exp v=1 d=1234 l=0", valid_o, data_o, last_o); end
        vectors++; if (level_o !== LW'(1)) begin errors++; $display("FAIL single_level1 got=%0d exp=1", level_o); end
        tick(1'b0, '0, '0, 1'b1, 1'b0);
        vectors++; if (valid_o !== 1'b1 || data_o !== 16'hABCD || last_o !== 1'b1)
            begin errors++; $display("FAIL single_imag got v=%b d=%h l=%b exp v=1 d=abcd l=1", valid_o, data_o, last_o); end
        tick(1'b0, '0, '0, 1'b1, 1'b0);
        vectors++; if (valid_o !== 1'b0 || level_o !== '0)
            begin errors++; $display("FAIL single_empty got v=%b lvl=%0d exp v=0 lvl=0", valid_o, level_o); end
    endtask

    task automatic test_backpressure();
        logic [DW-1:0] exp[6];
        for (int p = 0; p < 3; p++) begin
            exp[2*p]   = DW'($urandom);
            exp[2*p+1] = DW'($urandom);
            tick(1'b1, exp[2*p], exp[2*p+1], 1'b0, 1'b0);
        end
        for (int c = 0; c < 10; c++) begin
            vectors++; if (valid_o !== 1'b1 || data_o !== exp[0] || last_o !== 1'b0 || level_o !== LW'(3))
                begin errors++; $display("FAIL bp_hold c=%0d got v=%b d=%h l=%b lvl=%0d exp v=1 d=%h l=0 lvl=3",
                                         c, valid_o, data_o, last_o, level_o, exp[0]); end
            tick(1'b0, '0, '0, 1'b0, 1'b0);
        end
        for (int k = 0; k < 6; k++) begin
            vectors++; if (valid_o !== 1'b1 || data_o !== exp[k] || last_o !== (k % 2 == 1))
                begin errors++; $display("FAIL bp_drain k=%0d got v=%b d=%h l=%b exp v=1 d=%h l=%b",
                                         k, valid_o, data_o, last_o, exp[k], k % 2 == 1); end
            tick(1'b0, '0, '0, 1'b1, 1'b0);
        end
        vectors++; if (valid_o !== 1'b0) begin errors++; $display("FAIL bp_end got v=%b exp=0", valid_o); end
    endtask

    task automatic test_overflow();
        for (int n = 0; n < 10; n++) begin
            ov_i[n] = DW'($urandom);
            ov_q[n] = DW'($urandom);
            tick(1'b1, ov_i[n], ov_q[n], 1'b0, 1'b0);
        end
        vectors++; if (level_o !== LW'(DEPTH)) begin errors++; $display("FAIL ovf_level got=%0d exp=%0d", level_o, DEPTH); end
        vectors++; if (overflow_o !== 1'b1) begin errors++; $display("FAIL ovf_set got=%b exp=1", overflow_o); end
        vectors++; if (data_o !== ov_i[0]) begin errors++; $display("FAIL ovf_head got=%h exp=%h", data_o, ov_i[0]); end
`ifdef IQ_INTERLEAVER_DROP_CNT_EN
        vectors++; if (drop_cnt_o !== 16'd2) begin errors++; $display("FAIL ovf_cnt got=%0d exp=2", drop_cnt_o); end
`endif
        tick(1'b0, '0, '0, 1'b0, 1'b1);
        vectors++; if (overflow_o !== 1'b0) begin errors++; $display("FAIL ovf_clr got=%b exp=0", overflow_o); end
        vectors++; if (level_o !== LW'(DEPTH)) begin errors++; $display("FAIL ovf_clr_level got=%0d exp=%0d", level_o, DEPTH); end
`ifdef IQ_INTERLEAVER_DROP_CNT_EN
        vectors++; if (drop_cnt_o !== 16'd0) begin errors++; $display("FAIL ovf_cnt_clr got=%0d exp=0", drop_cnt_o); end
`endif
        tick(1'b0, '0, '0, 1'b0, 1'b0);
    endtask

    task automatic test_full_pop();
        logic [DW-1:0] ni, nq;
        logic [DW-1:0] exp[16];
        ni = DW'($urandom);
        nq = DW'($urandom);
        tick(1'b0, '0, '0, 1'b1, 1'b0);
        vectors++; if (last_o !== 1'b1 || data_o !== ov_q[0])
            begin errors++; $display("FAIL fp_imag got d=%h l=%b exp d=%h l=1", data_o, last_o, ov_q[0]); end
        tick(1'b1, ni, nq, 1'b1, 1'b0);
        vectors++; if (level_o !== LW'(DEPTH) || overflow_o !== 1'b0)
            begin errors++; $display("FAIL fp_accept got lvl=%0d ovf=%b exp lvl=%0d ovf=0", level_o, overflow_o, DEPTH); end
        for (int p = 1; p < 8; p++) begin
            exp[2*p-2] = ov_i[p];
            exp[2*p-1] = ov_q[p];
        end
        exp[14] = ni;
        exp[15] = nq;
        for (int k = 0; k < 16; k++) begin
            vectors++; if (valid_o !== 1'b1 || data_o !== exp[k] || last_o !== (k % 2 == 1))
                begin errors++; $display("FAIL fp_drain k=%0d got v=%b d=%h l=%b exp v=1 d=%h l=%b",
                                         k, valid_o, data_o, last_o, exp[k], k % 2 == 1); end
            tick(1'b0, '0, '0, 1'b1, 1'b0);
        end
        vectors++; if (valid_o !== 1'b0 || level_o !== '0)
            begin errors++; $display("FAIL fp_end got v=%b lvl=%0d exp v=0 lvl=0", valid_o, level_o); end
    endtask

    task automatic test_wrap();
        int sent = 0;
        int cyc  = 0;
        logic vi, rdy;
        logic [DW-1:0] ed;
        while ((sent < 40 || mq.size() > 0) && cyc < 2000) begin
            vectors++; if (valid_o !== (mq.size() > 0))
                begin errors++; $display("FAIL wrap_valid cyc=%0d got=%b exp=%b", cyc, valid_o, mq.size() > 0); end
            if (mq.size() > 0) begin
                ed = half ? mq[0][DW-1:0] : mq[0][2*DW-1:DW];
                vectors++; if (data_o !== ed || last_o !== half)
                    begin errors++; $display("FAIL wrap_beat cyc=%0d got d=%h l=%b exp d=%h l=%b", cyc, data_o, last_o, ed, half); end
            end
            vectors++; if (level_o !== LW'(mq.size()) || overflow_o !== m_ovf)
                begin errors++; $display("FAIL wrap_level cyc=%0d got lvl=%0d ovf=%b exp lvl=%0d ovf=%b",
                                         cyc, level_o, overflow_o, mq.size(), m_ovf); end
`ifdef IQ_INTERLEAVER_DROP_CNT_EN
            vectors++; if (drop_cnt_o !== m_cnt) begin errors++; $display("FAIL wrap_cnt got=%0d exp=%0d", drop_cnt_o, m_cnt); end
`endif
            vi  = (sent < 40) && ($urandom_range(3) == 0);
            rdy = (sent >= 40) || ($urandom_range(1) == 0);
            if (vi) sent++;
            tick(vi, DW'($urandom), DW'($urandom), rdy, 1'b0);
            cyc++;
        end
        vectors++; if (cyc >= 2000) begin errors++; $display("FAIL wrap_timeout cyc=%0d", cyc); end
        vectors++; if (overflow_o !== 1'b0) begin errors++; $display("FAIL wrap_no_drop got=%b exp=0", overflow_o); end
    endtask

    task automatic test_reset_mid();
        logic [DW-1:0] ni, nq;
        ni = DW'($urandom);
        nq = DW'($urandom);
        tick(1'b1, ni, nq, 1'b1, 1'b0);
        tick(1'b0, '0, '0, 1'b1, 1'b0);
        vectors++; if (last_o !== 1'b1) begin errors++; $display("FAIL rm_imag got l=%b exp=1", last_o); end
        rst = 1'b0;
        #1;
        vectors++; if (valid_o !== 1'b0 || last_o !== 1'b0 || data_o !== '0 || level_o !== '0 || overflow_o !== 1'b0)
            begin errors++; $display("FAIL rm_async got v=%b l=%b d=%h lvl=%0d ovf=%b exp all 0",
                                     valid_o, last_o, data_o, level_o, overflow_o); end
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        for (int c = 0; c < 3; c++) begin
            vectors++; if (valid_o !== 1'b0) begin errors++; $display("FAIL rm_orphan c=%0d got v=%b exp=0", c, valid_o); end
            tick(1'b0, '0, '0, 1'b1, 1'b0);
        end
        tick(1'b1, nq, ni, 1'b0, 1'b0);
        vectors++; if (valid_o !== 1'b1 || data_o !== nq || last_o !== 1'b0)
            begin errors++; $display("FAIL rm_new got v=%b d=%h l=%b exp v=1 d=%h l=0", valid_o, data_o, last_o, nq); end
    endtask

    initial begin
        valid_i = 1'b0; i_i = '0; q_i = '0; ready_i = 1'b0; clr_ovf_i = 1'b0;
        rst = 1'b1;
        #1 rst = 1'b0;
        @(negedge clk);
        test_reset();
        rst = 1'b1;
        @(negedge clk);
        test_single();
        test_backpressure();
        test_overflow();
        test_full_pop();
        test_wrap();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
